// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Expected parity bit for a given data XOR and parity type.
    function automatic logic expected_parity(input logic typ, input logic data_xor);
        logic res;
        res = data_xor;
        case (typ)
            PAR_EVEN: res = data_xor;
            PAR_ODD:  res = ~data_xor;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Per-bit oversampling edge counter and frame bit counter.
module uart_rx_edge_bit_counter #(
    parameter int unsigned Prescale_width = 6,
    parameter int unsigned n_bits         = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [Prescale_width-1:0] prescale,
    input  logic                      load,
    input  logic                      enable,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic [n_bits-1:0]         bit_cnt,
    output logic                      bit_done
);

    localparam int unsigned PW = Prescale_width;

    assign bit_done = enable && (edge_cnt == prescale - PW'(1));

    // load starts at 1: the start-detection cycle itself is edge 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            edge_cnt <= PW'(1);
            bit_cnt  <= '0;
        end else if (enable) begin
            if (bit_done) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + n_bits'(1);
            end else begin
                edge_cnt <= edge_cnt + PW'(1);
            end
        end else begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: majority-sampled bits, optional parity, one stop bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned Prescale_width = 6,
    parameter int unsigned DATA_width     = 8,
    parameter int unsigned n_bits         = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [Prescale_width-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      RX_IN,
    output logic [DATA_width-1:0]     P_DATA,
    output logic                      data_valid
);

    localparam int unsigned PW = Prescale_width;
    localparam int unsigned DW = DATA_width;

    state_t              state, state_next;
    logic [PW-1:0]       pre_q;
    logic                par_en_q, par_typ_q;
    logic [PW-1:0]       edge_cnt, half;
    logic [n_bits-1:0]   bit_cnt;
    logic                bit_done, enable;
    logic                at_s0, at_s1, at_s2;
    logic                s0, s1, maj, bit_val;
    logic [DW-1:0]       shift_reg;
    logic                par_err;
    logic                load, shift_en, par_chk, frame_done;

    assign enable = (state != IDLE);
    assign half   = pre_q >> 1;
    assign at_s0  = (edge_cnt == half - PW'(2));
    assign at_s1  = (edge_cnt == half - PW'(1));
    assign at_s2  = (edge_cnt == half);
    assign maj    = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);

    uart_rx_edge_bit_counter #(
        .Prescale_width(PW),
        .n_bits        (n_bits)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .prescale(pre_q),
        .load    (load),
        .enable  (enable),
        .edge_cnt(edge_cnt),
        .bit_cnt (bit_cnt),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (at_s2 && maj)  state_next = IDLE;
                else if (bit_done) state_next = DATA;
            end
            DATA: begin
                shift_en = at_s2;
                if (bit_done && bit_cnt == n_bits'(DW))
                    state_next = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                par_chk = at_s2;
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame settings are frozen at start detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (load) begin
            pre_q     <= Prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0      <= 1'b1;
            s1      <= 1'b1;
            bit_val <= 1'b1;
        end else begin
            if (at_s0) s0 <= RX_IN;
            if (at_s1) s1 <= RX_IN;
            if (at_s2) bit_val <= maj;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            par_err   <= 1'b0;
        end else if (load) begin
            shift_reg <= '0;
            par_err   <= 1'b0;
        end else begin
            if (shift_en) shift_reg <= {maj, shift_reg[DW-1:1]};
            if (par_chk)  par_err   <= (maj != expected_parity(par_typ_q, ^shift_reg));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= frame_done && bit_val && !par_err;
            if (frame_done && bit_val && !par_err) P_DATA <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good/bad frames, rates, glitch and mid-frame reset.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned PW = 6;
    localparam int unsigned DW = 8;
    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] Prescale;
    logic          PAR_EN, PAR_TYP, RX_IN;
    logic [DW-1:0] P_DATA;
    logic          data_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .Prescale_width(PW),
        .DATA_width    (DW),
        .n_bits        (NB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Prescale  (Prescale),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .RX_IN     (RX_IN),
        .P_DATA    (P_DATA),
        .data_valid(data_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting now (caller sits just after a rising edge).
    // Inputs are scrambled after detection to show they are latched.
    task automatic send(input string tag, input int p, input logic pen, input logic ptyp,
                        input logic [7:0] data, input logic pbit, input logic sbit,
                        input logic ok, input logic [7:0] exp);
        logic [11:0] bits;
        int          len;
        int          cnt;
        logic        early;
        early = 1'b0;
        cnt   = 0;
        len   = pen ? 11 : 10;
        bits  = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (pen) begin
            bits[9]  = pbit;
            bits[10] = sbit;
        end else begin
            bits[9] = sbit;
        end
        Prescale = PW'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        for (int i = 0; i < len; i++) begin
            RX_IN = bits[i];
            repeat (p) begin
                @(posedge clk);
                #1;
                cnt++;
                if (cnt == 1) begin
                    Prescale = PW'((p == 8) ? 16 : 8);
                    PAR_EN   = ~pen;
                    PAR_TYP  = ~ptyp;
                end
                if (cnt < len * p) early = early | data_valid;
            end
        end
        check({tag, " early pulse"}, 32'(early), 32'(0));
        check({tag, " data_valid"}, 32'(data_valid), 32'(ok));
        check({tag, " P_DATA"}, 32'(P_DATA), 32'(exp));
    endtask

    initial begin
        logic seen;
        reset    = 1'b1;
        RX_IN    = 1'b1;
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset P_DATA", 32'(P_DATA), 32'(0));
        check("reset data_valid", 32'(data_valid), 32'(0));
        check("reset state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Frames chained with zero idle gap between them
        send("even 4D p8",  8,  1'b1, PAR_EVEN, 8'h4D, 1'b0, 1'b1, 1'b1, 8'h4D);
        send("odd 59 p8",   8,  1'b1, PAR_ODD,  8'h59, 1'b1, 1'b1, 1'b1, 8'h59);
        send("nopar 92 p8", 8,  1'b0, PAR_EVEN, 8'h92, 1'b0, 1'b1, 1'b1, 8'h92);
        send("stop err 67", 8,  1'b0, PAR_EVEN, 8'h67, 1'b0, 1'b0, 1'b0, 8'h92);
        send("par err 92",  8,  1'b1, PAR_EVEN, 8'h92, 1'b0, 1'b1, 1'b0, 8'h92);
        send("even 4D p16", 16, 1'b1, PAR_EVEN, 8'h4D, 1'b0, 1'b1, 1'b1, 8'h4D);
        send("even 4D p32", 32, 1'b1, PAR_EVEN, 8'h4D, 1'b0, 1'b1, 1'b1, 8'h4D);
        RX_IN = 1'b1;
        @(posedge clk);
        #1;
        check("p32 single pulse", 32'(data_valid), 32'(0));

        // One-cycle low on the line must be rejected
        Prescale = PW'(8);
        repeat (4) @(posedge clk);
        #1;
        RX_IN = 1'b0;
        @(posedge clk);
        #1;
        RX_IN = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | data_valid;
        end
        check("glitch data_valid", 32'(seen), 32'(0));
        check("glitch state", 32'(dut.state), 32'(IDLE));
        check("glitch P_DATA", 32'(P_DATA), 32'(8'h4D));

        // Reset in the middle of a frame
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        RX_IN = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check("midreset P_DATA", 32'(P_DATA), 32'(0));
        check("midreset data_valid", 32'(data_valid), 32'(0));
        check("midreset state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send("after reset A5", 8, 1'b0, PAR_EVEN, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5);
        RX_IN = 1'b1;
        @(posedge clk);
        #1;
        check("after reset single pulse", 32'(data_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
